// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the iterative 64-bit RV64M divider: special cases, sign fixup, W form.
// Optional macro MULDIV_PAIR_CACHE_EN adds a one-entry result cache for repeated operand pairs.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  output logic        du_start,
  output logic        du_kill,
  output logic [63:0] du_dividend,
  output logic [63:0] du_divisor,
  input  logic        du_done,
  input  logic [63:0] du_quotient,
  input  logic [63:0] du_remainder,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        start_q, start_d, kill_q, kill_d;
  logic [63:0] dividend_q, dividend_d, divisor_q, divisor_d;
  logic [63:0] result_q, result_d;
  logic        rem_q, rem_d, word_q, word_d;
  logic        neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;

  logic        op_signed, op_rem, op_word;
  logic [63:0] a_ext, b_ext, min_val;
  logic        a_neg, b_neg;
  logic        accept, div_zero, overflow;
  logic [63:0] fix_quot, fix_rem;

  assign op_signed = ~req_op[0];
  assign op_rem    = req_op[1];
  assign op_word   = req_op[2];

  always_comb begin
    if (op_word) begin
      a_ext = {{32{op_signed & req_src1[31]}}, req_src1[31:0]};
      b_ext = {{32{op_signed & req_src2[31]}}, req_src2[31:0]};
    end else begin
      a_ext = req_src1;
      b_ext = req_src2;
    end
  end

  assign a_neg     = op_signed & a_ext[63];
  assign b_neg     = op_signed & b_ext[63];
  assign min_val   = op_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign div_zero  = (b_ext == '0);
  assign overflow  = op_signed && (a_ext == min_val) && (b_ext == '1);
  assign req_ready = (state_q == StIdle) && !flush && !rst;
  assign accept    = req_valid && req_ready;
  assign fix_quot  = neg_quot_q ? -du_quotient : du_quotient;
  assign fix_rem   = neg_rem_q ? -du_remainder : du_remainder;

  function automatic logic [63:0] select_result(input logic [63:0] quot, input logic [63:0] rem,
                                                input logic is_rem, input logic is_word);
    logic [63:0] val;
    val = is_rem ? rem : quot;
    return is_word ? {{32{val[31]}}, val[31:0]} : val;
  endfunction

`ifdef MULDIV_PAIR_CACHE_EN
  logic        cache_valid_q, cache_signed_q, cache_word_q, signed_q;
  logic [63:0] cache_a_q, cache_b_q, cache_quot_q, cache_rem_q, op_a_q, op_b_q;
  logic        cache_hit, cache_fill;

  assign cache_hit  = cache_valid_q && (cache_a_q == a_ext) && (cache_b_q == b_ext) &&
                      (cache_signed_q == op_signed) && (cache_word_q == op_word);
  assign cache_fill = (state_q == StRun) && du_done && !flush;

  // Refreshed only by completed divider runs; flush and special cases leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q  <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_word_q   <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_quot_q   <= '0;
      cache_rem_q    <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      signed_q       <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q   <= a_ext;
        op_b_q   <= b_ext;
        signed_q <= op_signed;
      end
      if (cache_fill) begin
        cache_valid_q  <= 1'b1;
        cache_a_q      <= op_a_q;
        cache_b_q      <= op_b_q;
        cache_signed_q <= signed_q;
        cache_word_q   <= word_q;
        cache_quot_q   <= fix_quot;
        cache_rem_q    <= fix_rem;
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    kill_d     = 1'b0;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    rem_d      = rem_q;
    word_d     = word_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rem_d  = op_rem;
          word_d = op_word;
          if (div_zero) begin
            state_d  = StDone;
            result_d = select_result('1, a_ext, op_rem, op_word);
          end else if (overflow) begin
            state_d  = StDone;
            result_d = select_result(a_ext, '0, op_rem, op_word);
`ifdef MULDIV_PAIR_CACHE_EN
          end else if (cache_hit) begin
            state_d  = StDone;
            result_d = select_result(cache_quot_q, cache_rem_q, op_rem, op_word);
`endif
          end else begin
            state_d    = StRun;
            start_d    = 1'b1;
            dividend_d = a_neg ? -a_ext : a_ext;
            divisor_d  = b_neg ? -b_ext : b_ext;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
          end
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
          kill_d  = 1'b1;
        end else if (du_done) begin
          state_d  = StDone;
          result_d = select_result(fix_quot, fix_rem, rem_q, word_q);
        end
      end
      StDone: begin
        if (flush || resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      kill_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      rem_q      <= 1'b0;
      word_q     <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      kill_q     <= kill_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      rem_q      <= rem_d;
      word_q     <= word_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign du_start    = start_q;
  assign du_kill     = kill_q;
  assign du_dividend = dividend_q;
  assign du_divisor  = divisor_q;
  assign resp_valid  = (state_q == StDone);
  assign resp_data   = result_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the iterative 64-bit divider in the execute stage. Accepts RV64M divide/remainder requests from EX with a valid/ready handshake and resolves divide-by-zero and signed overflow without using the divider. All other requests are passed to the divider as unsigned magnitudes. The controller then applies sign correction and W-form sign extension, and holds the result until writeback accepts it.

## Interface
- No parameters; data width fixed at 64.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush; aborts any in-flight operation.
- `req_valid` in 1: EX presents a request.
- `req_ready` out 1: controller accepts a request this cycle.
- `req_op` in 3: bit0 = unsigned, bit1 = remainder, bit2 = word form. 000 DIV, 001 DIVU, 010 REM, 011 REMU, 1xx = the W variants.
- `req_src1` in 64: dividend (rs1).
- `req_src2` in 64: divisor (rs2).
- `du_start` out 1: one-cycle start pulse to the divider.
- `du_kill` out 1: one-cycle abort pulse to the divider.
- `du_dividend` out 64: unsigned magnitude, held stable while the divider runs.
- `du_divisor` out 64: unsigned magnitude, held stable while the divider runs.
- `du_done` in 1: divider result valid (single-cycle pulse).
- `du_quotient` in 64: unsigned quotient from the divider.
- `du_remainder` in 64: unsigned remainder from the divider.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: writeback accepts the result.
- `resp_data` out 64: final rd value.
- `busy` out 1: high whenever state ≠ IDLE; used as the EX stall source.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `req_ready = !flush`.
  - On accept, latch op and the extended operands.
- **Operand extension:**
  - W form: low 32 bits of each source, sign-extended if signed, zero-extended if unsigned.
  - Otherwise: full 64 bits.
- **Special cases on accept** (go to DONE, no `du_start`):
  - Divisor == 0: quotient = all ones; remainder = extended dividend.
  - Signed overflow: dividend = most-negative value of the operating width and divisor = −1. Quotient = dividend; remainder = 0.
  - Otherwise go to RUN.
- **RUN:**
  - `du_start` pulses on the first RUN cycle only.
  - Magnitudes are the two's-complement absolute value when signed and negative; otherwise the operand unchanged.
  - Wait for `du_done`, then capture quotient and remainder and go to DONE.
- **Sign fixup** (signed ops only):
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend is negative.
- **Result select:** quotient or remainder per op bit1.
- **W form result:** bits [31:0] sign-extended to 64, for both signed and unsigned W ops.
- **DONE:**
  - `resp_valid = 1` and `resp_data` holds stable until `resp_valid && resp_ready`, then go to IDLE.
  - A new request is not accepted in that same cycle.
- **Flush:** highest priority in every state.
  - Next state is IDLE and the pending result is discarded.
  - `du_kill` pulses for one cycle if flush occurs in RUN.
  - A `du_done` coinciding with flush is ignored.
  - Flush in DONE coinciding with `resp_ready` counts as no handshake.

## Timing
- **Reset values:**
  - `req_ready` = 0 during the reset cycle, 1 after.
  - `du_start`, `du_kill`, `resp_valid`, `busy` = 0.
  - `du_dividend`, `du_divisor`, `resp_data` = 0.
  - State = IDLE.
- **Latencies:**
  - Special case: accept at cycle N, `resp_valid` at N+1.
  - Normal: accept at N, `du_start` at N+1, `du_done` at cycle M, `resp_valid` at M+1.
- `du_start` and `du_kill` are registered outputs and are never high together.
- Operand and output registers hold across `resp_ready` stalls; there is no combinational path from `resp_ready` to `resp_data`.
- Reset mid-RUN returns to IDLE without `du_kill`; the divider shares `rst`.

## Configuration
- Macro: `MULDIV_PAIR_CACHE_EN`.
- **Defined:** a one-entry cache stores the extended operands, the signed and word flags, and the final signed quotient and remainder of the last divider run that completed.
  - A request whose operands and flags match a valid entry goes IDLE → DONE in one cycle without `du_start`. This covers a DIV followed by a REM, or any repeat.
  - Entry is cleared by `rst` and refreshed only when a divider run completes (not when it is killed or takes a special case).
- **Undefined:** no cache storage; every non-special request goes through RUN.

## Test plan
- DIV src1 = −7, src2 = 2 → quotient −3 (0xFFFF_FFFF_FFFF_FFFD). REM of the same operands → −1. `du_start` pulses exactly once per request.
- DIVU src1 = 100, src2 = 0 → `resp_data` = 0xFFFF_FFFF_FFFF_FFFF at accept+1, with no `du_start`. REMU of the same operands → 100.
- DIV src1 = 0x8000_0000_0000_0000, src2 = −1 → 0x8000_0000_0000_0000. REMW src1 = 0x8000_0000, src2 = 0xFFFF_FFFF → 0.
- DIVUW src1 = 0x1_FFFF_FFFE, src2 = 1 → 0xFFFF_FFFF_FFFF_FFFE. Hold `resp_ready` low for 5 cycles → `resp_data` stable and `req_ready` = 0 throughout.
- Flush on the 3rd RUN cycle, with `du_done` forced in the same cycle → `du_kill` pulses once, no `resp_valid`, IDLE next cycle. A following DIV 9/3 → 3.
- With `MULDIV_PAIR_CACHE_EN` defined: DIV 17/5 then REM 17/5 → 3, then 2. The second result arrives at accept+1 with no `du_start`.
